// File: rtl/tmds_rx_fifo_sched_if.sv
// -----------------------------------------------------------------------------
// tmds_rx_fifo_sched_if
// Read-side bundle of the two first-word-fall-through FIFOs feeding the TMDS
// receive scheduler: the 29-bit video FIFO and the 35-bit aux FIFO.
//
// Signals
//   video_dout  [28:0]  video FIFO head word ([28:27] x-seg, [26:16] line, [15:0] pixel)
//   video_empty         video FIFO empty (head valid while low)
//   video_rd_en         video FIFO pop
//   aux_dout    [34:0]  aux FIFO head word ([34:24] line, [8:0] aux symbol)
//   aux_empty           aux FIFO empty
//   aux_rd_en           aux FIFO pop
//
// Modports
//   master : the scheduler (consumes head words, drives the pops)
//   slave  : the FIFO side (drives head words and empty flags)
// -----------------------------------------------------------------------------
interface tmds_rx_fifo_sched_if;
    logic [28:0] video_dout;
    logic        video_empty;
    logic        video_rd_en;
    logic [34:0] aux_dout;
    logic        aux_empty;
    logic        aux_rd_en;

    modport master (
        input  video_dout, video_empty, aux_dout, aux_empty,
        output video_rd_en, aux_rd_en
    );

    modport slave (
        output video_dout, video_empty, aux_dout, aux_empty,
        input  video_rd_en, aux_rd_en
    );
endinterface

// File: rtl/tmds_rx_fifo_sched.sv
// -----------------------------------------------------------------------------
// tmds_rx_fifo_sched
// pclk-side read scheduler for the GMII->TMDS receive path. Pops the video and
// aux FIFOs in step with local TMDS timing: each video line is aligned to the
// local line counter (stale words are discarded, early words make the line
// wait), and aux symbols are streamed only during blanking.
//
// Ports
//   pclk_i       TMDS pixel clock (sole clock)
//   tmds_rst_i   asynchronous reset, active-high
//   hsync_i      local timing hsync
//   vsync_i      local timing vsync
//   vde_i        local active-video enable
//   fifo_if      video/aux FIFO read bundle (master modport)
//   video_o      registered pixel, BLACK when the delayed vde is low
//   video_de_o   vde delayed by one cycle
//   aux_o        last popped aux symbol
//   aux_valid_o  aux_o was popped in the previous cycle
//   line_cnt_o   local line counter
//   drop_cnt_o   saturating count of discarded stale video words
//   underrun_o   sticky: video FIFO empty on a streaming vde cycle
// -----------------------------------------------------------------------------
module tmds_rx_fifo_sched #(
    parameter int unsigned DROP_MAX = 64,
    parameter int unsigned AUX_MAX  = 32,
    parameter logic [15:0] BLACK    = 16'h0000
) (
    input  logic                  pclk_i,
    input  logic                  tmds_rst_i,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    input  logic                  vde_i,
    tmds_rx_fifo_sched_if.master  fifo_if,
    output logic [15:0]           video_o,
    output logic                  video_de_o,
    output logic [8:0]            aux_o,
    output logic                  aux_valid_o,
    output logic [10:0]           line_cnt_o,
    output logic [15:0]           drop_cnt_o,
    output logic                  underrun_o
);
    localparam int unsigned DB_W = $clog2(DROP_MAX + 1);
    localparam int unsigned AB_W = $clog2(AUX_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_READY, S_STREAM, S_WAIT
    } state_t;

    state_t          state_q, state_d;

    logic            hs_q, vs_q, vde_q;
    logic            hs_rise, vs_rise, vde_rise, vde_fall;

    logic [10:0]     line_cnt_q, line_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [DB_W-1:0] drop_bud_q, drop_bud_d;
    logic [AB_W-1:0] aux_bud_q, aux_bud_d;
    logic [15:0]     video_q, video_d;
    logic            video_de_q;
    logic [8:0]      aux_q, aux_d;
    logic            aux_valid_q;
    logic            underrun_q, underrun_d;

    logic [10:0]     line_diff;
    logic            line_match, line_stale;
    logic            vid_pop, drop_en, px_load, px_under, aux_pop;

    // Line fields of the aux words and the x-segment are not used here.
    logic            unused_bits;
    assign unused_bits = ^{fifo_if.video_dout[28:27], fifo_if.aux_dout[34:9]};

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hs_rise  = hsync_i & ~hs_q;
    assign vs_rise  = vsync_i & ~vs_q;
    assign vde_rise = vde_i & ~vde_q;
    assign vde_fall = ~vde_i & vde_q;

    // Modular distance from the head word's line to the local line: the lower
    // half of the circle is "behind us" (stale), the upper half is "ahead".
    assign line_diff  = line_cnt_q - fifo_if.video_dout[26:16];
    assign line_match = (line_diff == 11'd0);
    assign line_stale = ~line_match & ~line_diff[10];

    // FSM state register
    always_ff @(posedge pclk_i or posedge tmds_rst_i) begin
        if (tmds_rst_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hs_rise) state_d = S_ALIGN;
            S_ALIGN: begin
                if (vde_i) begin
                    state_d = S_WAIT;
                end else if (!fifo_if.video_empty) begin
                    if (line_match)                   state_d = S_READY;
                    else if (!line_stale)             state_d = S_WAIT;
                    else if (drop_bud_q <= DB_W'(1))  state_d = S_WAIT;
                end
            end
            S_READY:  if (vde_rise) state_d = S_STREAM;
            S_STREAM,
            S_WAIT:   if (vde_fall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Frame start resynchronises everything.
        if (vs_rise) state_d = S_IDLE;
    end

    // FSM outputs: video pops, drops and pixel source selection
    always_comb begin
        vid_pop  = 1'b0;
        drop_en  = 1'b0;
        px_load  = 1'b0;
        px_under = 1'b0;
        case (state_q)
            S_ALIGN: begin
                if (!vde_i && !fifo_if.video_empty && line_stale) begin
                    vid_pop = 1'b1;
                    drop_en = 1'b1;
                end
            end
            // The vde rise cycle in READY is already the first pixel of the line.
            S_READY, S_STREAM: begin
                if ((state_q == S_READY) ? vde_rise : vde_i) begin
                    if (!fifo_if.video_empty) begin
                        vid_pop = 1'b1;
                        px_load = 1'b1;
                    end else begin
                        px_under = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign aux_pop = ~vde_i & ~fifo_if.aux_empty & (aux_bud_q != '0) &
                     (state_q != S_ALIGN);

    assign fifo_if.video_rd_en = vid_pop;
    assign fifo_if.aux_rd_en   = aux_pop;

    // Datapath next state
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (vs_rise)       line_cnt_d = 11'd0;
        else if (vde_fall) line_cnt_d = line_cnt_q + 11'd1;

        drop_cnt_d = drop_en ? sat_inc16(drop_cnt_q) : drop_cnt_q;

        drop_bud_d = drop_bud_q;
        if (state_q == S_IDLE && hs_rise) drop_bud_d = DB_W'(DROP_MAX);
        else if (drop_en)                 drop_bud_d = drop_bud_q - DB_W'(1);

        aux_bud_d = aux_bud_q;
        if (vde_rise)     aux_bud_d = AB_W'(AUX_MAX);
        else if (aux_pop) aux_bud_d = aux_bud_q - AB_W'(1);

        video_d    = px_load ? fifo_if.video_dout[15:0] : BLACK;
        aux_d      = aux_pop ? fifo_if.aux_dout[8:0] : aux_q;
        underrun_d = underrun_q | px_under;
    end

    // Edge-detect, counters and output registers
    always_ff @(posedge pclk_i or posedge tmds_rst_i) begin
        if (tmds_rst_i) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            vde_q       <= 1'b0;
            line_cnt_q  <= 11'd0;
            drop_cnt_q  <= 16'd0;
            drop_bud_q  <= DB_W'(DROP_MAX);
            aux_bud_q   <= AB_W'(AUX_MAX);
            video_q     <= 16'd0;
            video_de_q  <= 1'b0;
            aux_q       <= 9'd0;
            aux_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hs_q        <= hsync_i;
            vs_q        <= vsync_i;
            vde_q       <= vde_i;
            line_cnt_q  <= line_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_bud_q  <= drop_bud_d;
            aux_bud_q   <= aux_bud_d;
            video_q     <= video_d;
            video_de_q  <= vde_i;
            aux_q       <= aux_d;
            aux_valid_q <= aux_pop;
            underrun_q  <= underrun_d;
        end
    end

    assign video_o     = video_q;
    assign video_de_o  = video_de_q;
    assign aux_o       = aux_q;
    assign aux_valid_o = aux_valid_q;
    assign line_cnt_o  = line_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign underrun_o  = underrun_q;
endmodule
